// File: rtl/bitrev_stream_ctrl_pkg.sv
// Shared types and helpers for the bit-reversal stream controller.
// complex_t is one packed complex sample; bitrev() reverses the low nbits of an index.
package bitrev_stream_ctrl_pkg;

  localparam int unsigned CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } complex_t;

  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = idx;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b < nbits) begin
        r = (r << 1) | (v & 32'd1);
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank_ram.sv
// One N-entry sample bank: single write port, registered read port with enable.
// The read register doubles as the output-stage data register, so it resets to zero.
module reorder_bank_ram
  import bitrev_stream_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [$clog2(N)-1:0] waddr_i,
  input  complex_t             wdata_i,
  input  logic                 re_i,
  input  logic [$clog2(N)-1:0] raddr_i,
  output complex_t             rdata_o
);

  complex_t mem_q [N];
  complex_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bitrev_stream_ctrl.sv
// Ping-pong bit-reversal reorder controller for N-sample complex frames.
// Optional in_last/frame_err framing check is enabled by BITREV_FRAME_CHECK_EN.
module bitrev_stream_ctrl
  import bitrev_stream_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  complex_t             in_data,
`ifdef BITREV_FRAME_CHECK_EN
  input  logic                 in_last,
  output logic                 frame_err,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output complex_t             out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_idx
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic          out_bank_q, out_bank_d;

  logic          wr_fire, load, frame_bad;
  logic [AW-1:0] rd_addr;
  complex_t      rdata [2];

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign load     = full_q[rd_bank_q] && (!out_valid_q || out_ready);
  assign rd_addr  = AW'(bitrev(32'(rd_cnt_q), AW));

`ifdef BITREV_FRAME_CHECK_EN
  logic frame_err_q;

  assign frame_bad = wr_fire && (in_last != (wr_cnt_q == LAST));
  assign frame_err = frame_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          frame_err_q <= 1'b0;
    else if (frame_bad) frame_err_q <= 1'b1;
  end
`else
  assign frame_bad = 1'b0;
`endif

  // Write and read sides touch different banks, so a set and a clear of full can land together.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_bank_d  = out_bank_q;

    if (wr_fire) begin
      if (frame_bad) begin
        wr_cnt_d = '0;
      end else if (wr_cnt_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_idx_d   = rd_addr;
      out_last_d  = (rd_cnt_q == LAST);
      out_bank_d  = rd_bank_q;
      if (rd_cnt_q == LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_bank_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_bank_q  <= out_bank_d;
    end
  end

  // Each bank's read register is the output data stage; out_bank_q picks the live one.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank_ram #(
      .N(N)
    ) u_ram (
      .clk_i   (clk),
      .rst_i   (reset),
      .we_i    (wr_fire && (wr_bank_q == 1'(b))),
      .waddr_i (wr_cnt_q),
      .wdata_i (in_data),
      .re_i    (load && (rd_bank_q == 1'(b))),
      .raddr_i (rd_addr),
      .rdata_o (rdata[b])
    );
  end

  assign out_data  = rdata[out_bank_q];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_bitrev_stream_ctrl.sv
// Bench for bitrev_stream_ctrl: directed and random streams against a frame-permutation model.
module tb_bitrev_stream_ctrl;
  import bitrev_stream_ctrl_pkg::*;

  localparam int N  = 16;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  complex_t      in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  complex_t      out_data;
  logic          out_last;
  logic [AW-1:0] out_idx;
`ifdef BITREV_FRAME_CHECK_EN
  logic          frame_err;
`endif

  bitrev_stream_ctrl #(
    .N(N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef BITREV_FRAME_CHECK_EN
    .in_last   (in_last),
    .frame_err (frame_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    complex_t data;
    int       idx;
    bit       last;
  } exp_t;

  exp_t          exp_q[$];
  complex_t      frame_buf[$];
  int            obs_re[$];
  int            obs_idx[$];
  int            n_err = 0;
  int            n_chk = 0;
  int            cyc = 0;
  int            out_cnt = 0;
  int            first_out_cyc = -1;
  int            last_in_cyc = -1;
  int            force_last_at = -1;
  bit            hold_pend = 1'b0;
  bit            exp_ferr = 1'b0;
  complex_t      hold_data;
  logic [AW-1:0] hold_idx;
  logic          hold_last;

  function automatic int rev(input int j);
    int r = 0;
    for (int b = 0; b < AW; b++)
      if (((j >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    frame_buf.delete();
    hold_pend = 1'b0;
    exp_ferr  = 1'b0;
  endtask

  // One clock: check outputs against the model, account for transfers, advance to next negedge.
  task automatic step();
    logic in_fire, out_fire;
    in_last  = (frame_buf.size() == N - 1) || (frame_buf.size() == force_last_at);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;

    if (hold_pend) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, hold_data);
      chk("hold_idx", out_idx, hold_idx);
      chk("hold_last", out_last, hold_last);
    end
    hold_pend = out_valid && !out_ready;
    hold_data = out_data;
    hold_idx  = out_idx;
    hold_last = out_last;

    chk("valid_without_data", out_valid && (exp_q.size() == 0), 1'b0);
`ifdef BITREV_FRAME_CHECK_EN
    chk("frame_err", frame_err, exp_ferr);
`endif
    if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;

    if (out_fire && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("out_data", out_data, e.data);
      chk("out_idx", out_idx, e.idx);
      chk("out_last", out_last, e.last);
      obs_re.push_back(int'(out_data.re));
      obs_idx.push_back(int'(out_idx));
      out_cnt++;
    end

    if (in_fire) begin
      last_in_cyc = cyc;
      if (in_last != (frame_buf.size() == N - 1)) begin
        frame_buf.delete();
        exp_ferr = 1'b1;
      end else begin
        frame_buf.push_back(in_data);
        if (frame_buf.size() == N) begin
          for (int j = 0; j < N; j++) begin
            exp_t e;
            e.data = frame_buf[rev(j)];
            e.idx  = rev(j);
            e.last = (j == N - 1);
            exp_q.push_back(e);
          end
          frame_buf.delete();
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ref034[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int sent, base, guard, rdy_low, gaps;
    bit seen;
    complex_t first_data;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef BITREV_FRAME_CHECK_EN
    chk("rst_frame_err", frame_err, 1'b0);
`endif
    reset = 1'b0;
    clear_model();

    // Directed ramp r=k, i=-k
    out_ready = 1'b1;
    first_out_cyc = -1;
    obs_re.delete();
    obs_idx.delete();
    base = out_cnt;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data.re = 16'(k);
      in_data.im = 16'(-k);
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    while (out_cnt - base < N && guard < 100) begin step(); guard++; end
    chk("t034_count", out_cnt - base, N);
    for (int i = 0; i < N; i++) begin
      chk("t034_order_re", (i < obs_re.size()) ? obs_re[i] : -1, ref034[i]);
      chk("t034_order_idx", (i < obs_idx.size()) ? obs_idx[i] : -1, ref034[i]);
    end
    chk("t034_latency", first_out_cyc - last_in_cyc, 2);

    // Four back-to-back frames, full throughput
    sent = 0; base = out_cnt; guard = 0; rdy_low = 0; gaps = 0; seen = 1'b0;
    out_ready = 1'b1;
    while (out_cnt - base < 4 * N && guard < 400) begin
      in_valid = (sent < 4 * N);
      in_data  = complex_t'($urandom);
      if (sent >= N && sent < 4 * N && !in_ready) rdy_low++;
      if (out_valid) seen = 1'b1;
      else if (seen) gaps++;
      if (in_valid && in_ready) sent++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    chk("t035_count", out_cnt - base, 4 * N);
    chk("t035_in_ready_low", rdy_low, 0);
    chk("t035_valid_gaps", gaps, 0);

    // Output stalled while three frames are offered
    sent = 0; base = out_cnt; seen = 1'b0;
    out_ready = 1'b0;
    first_data = '0;
    for (int s = 0; s < 60; s++) begin
      in_valid = 1'b1;
      in_data  = complex_t'($urandom);
      if (out_valid && !seen) begin seen = 1'b1; first_data = out_data; end
      if (in_valid && in_ready) sent++;
      step();
    end
    chk("t036_accepts", sent, 32);
    chk("t036_in_ready", in_ready, 1'b0);
    chk("t036_out_valid", out_valid, 1'b1);
    chk("t036_stable", out_data, first_data);
    out_ready = 1'b1;
    guard = 0;
    while ((sent < 3 * N || out_cnt - base < 3 * N) && guard < 300) begin
      in_valid = (sent < 3 * N);
      in_data  = complex_t'($urandom);
      if (in_valid && in_ready) sent++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    chk("t036_count", out_cnt - base, 3 * N);

    // Asynchronous reset at sample 7 of the second frame
    out_ready = 1'b1;
    for (int s = 0; s < N + 7; s++) begin
      in_valid = 1'b1;
      in_data  = complex_t'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("t037_pre_valid", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t037_out_valid", out_valid, 1'b0);
    chk("t037_out_data", out_data, 32'h0);
    chk("t037_out_idx", out_idx, 0);
    chk("t037_out_last", out_last, 1'b0);
    chk("t037_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    obs_idx.delete();
    base = out_cnt;
    for (int s = 0; s < N; s++) begin
      in_valid = 1'b1;
      in_data  = complex_t'($urandom);
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    while (out_cnt - base < N && guard < 100) begin step(); guard++; end
    chk("t037_count", out_cnt - base, N);
    chk("t037_first_idx", (obs_idx.size() > 0) ? obs_idx[0] : -1, 0);

    // Random valid/ready traffic over five frames
    sent = 0; base = out_cnt; guard = 0;
    while (out_cnt - base < 5 * N && guard < 3000) begin
      in_valid  = (sent < 5 * N) && ($urandom_range(0, 3) != 0);
      in_data   = complex_t'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      if (in_valid && in_ready) sent++;
      step();
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t038_count", out_cnt - base, 5 * N);
    chk("t038_model_empty", exp_q.size() + frame_buf.size(), 0);

`ifdef BITREV_FRAME_CHECK_EN
    // Early in_last drops the partial frame and latches frame_err
    chk("t039_err_before", frame_err, 1'b0);
    base = out_cnt;
    force_last_at = 9;
    for (int s = 0; s < 10; s++) begin
      in_valid = 1'b1;
      in_data  = complex_t'($urandom);
      step();
    end
    force_last_at = -1;
    in_valid = 1'b0;
    step();
    chk("t039_err_set", frame_err, 1'b1);
    for (int s = 0; s < N; s++) begin
      in_valid = 1'b1;
      in_data  = complex_t'($urandom);
      step();
    end
    in_valid = 1'b0;
    guard = 0;
    while (out_cnt - base < N && guard < 100) begin step(); guard++; end
    repeat (4) step();
    chk("t039_count", out_cnt - base, N);
    chk("t039_err_sticky", frame_err, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bitrev_stream_ctrl.md
BITREV_STREAM_CTRL -- requirements
Module: bitrev_stream_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: frame length in complex samples; power of two, 4..1024.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  input sample valid.
REQ-005 SHALL have port in_ready  output  1  controller accepts a sample this cycle.
REQ-006 SHALL have port in_data  input  complex_t  natural-order input sample.
REQ-007 SHALL have port out_valid  output  1  output sample valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts a sample.
REQ-009 SHALL have port out_data  output  complex_t  bit-reversed-order output sample.
REQ-010 SHALL have port out_last  output  1  marks output index N-1 of a frame.
REQ-011 SHALL have port out_idx  output  $clog2(N)  natural-order index of the sample on out_data.

Function
REQ-012 SHALL hold two banks of N complex_t (ping-pong); each bank carries a full flag.
REQ-013 SHALL define a transfer as valid&&ready on a rising edge, on either port.
REQ-014 SHALL write accepted input k (0..N-1, counted by wr_cnt) to bank wr_bank, address k.
REQ-015 SHALL drive in_ready = !full[wr_bank], combinationally from registered state only.
REQ-016 SHALL, on the transfer with wr_cnt==N-1, set full[wr_bank], toggle wr_bank and clear wr_cnt.
REQ-017 SHALL emit read step j (rd_cnt 0..N-1) as bank[rd_bank][bitrev(j)], with out_idx=bitrev(j) and out_last=(j==N-1).
REQ-018 SHALL register out_data/out_idx/out_last/out_valid; the stage loads when full[rd_bank] is set and (!out_valid || out_ready).
REQ-019 SHALL hold out_data, out_idx and out_last stable while out_valid && !out_ready.
REQ-020 SHALL give latency: input N-1 accepted at edge t -> out_valid high after edge t+1 carrying input sample 0.
REQ-021 SHALL sustain one sample per clock on each port once both banks rotate, with no bubble between frames.
REQ-022 SHALL clear full[rd_bank], toggle rd_bank and clear rd_cnt when the out_last sample is loaded into the output stage.
REQ-023 SHALL let a write and a bank release in the same cycle both take effect; the released bank shows in_ready=1 on the next cycle.
REQ-024 SHALL stall input (in_ready=0) when both banks are full and never overwrite unread data.
REQ-025 SHALL never assert out_valid when neither bank is full and the output stage is empty.

Reset
REQ-026 SHALL, on reset assertion, asynchronously clear: full flags, wr_bank, rd_bank, wr_cnt, rd_cnt, out_valid, out_last, out_idx=0, out_data=0.
REQ-027 SHALL, on reset assertion mid-frame, discard all partial and full frames; bank contents need not be cleared.

Configuration
REQ-028 SHALL support macro BITREV_FRAME_CHECK_EN.
REQ-029 SHALL, with BITREV_FRAME_CHECK_EN defined, add input in_last (1) and output frame_err (1, sticky, reset 0).
REQ-030 SHALL, with the macro defined, set frame_err when in_last mismatches (wr_cnt==N-1) on a transfer, and drop the partial frame by clearing wr_cnt.
REQ-031 SHALL, without the macro, omit in_last and frame_err; framing is by count only.

Structure
REQ-032 SHALL take complex_t and a bitrev(idx, nbits) function from the shared header package.
REQ-033 SHALL instantiate one sub-module, reorder_bank_ram (1 write port, 1 registered read port, N entries), twice.

Verification
REQ-034 SHALL cover: reset, then 16 samples r=k, i=-k with out_ready=1 -> outputs r=0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with matching out_idx; out_last on the 16th.
REQ-035 SHALL cover: 4 back-to-back frames with in_valid=out_ready=1 -> in_ready is never low after the first frame, and out_valid is continuous from its first assertion.
REQ-036 SHALL cover: out_ready=0 held while 3 frames are offered -> in_ready drops after 32 accepts, and out_data is stable throughout.
REQ-037 SHALL cover: reset asserted at input sample 7 of frame 2 -> all outputs return to 0 asynchronously, and the next frame starts at index 0.
REQ-038 SHALL cover: out_ready toggled randomly at 50% -> every output frame equals the bit-reverse of its input frame, with no loss or duplication.
REQ-039 SHALL cover: with BITREV_FRAME_CHECK_EN defined, in_last at sample 9 -> frame_err=1, that frame is never output, and the next frame is correct.
